// File: rtl/data_bus_arbiter_pkg.sv
// Shared encodings for the data bus arbiter: slave bus_state codes,
// transfer sizes and the arbiter FSM state type.
package bus_pkg;

  localparam logic [1:0] BS_IDLE = 2'b00;
  localparam logic [1:0] BS_BUSY = 2'b01;
  localparam logic [1:0] BS_DONE = 2'b10;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Master request/response signals and slave-side bus signals of the data
// bus arbiter. The arbiter connects through modport master; the
// environment (CPU, debug master and busdev slaves) uses modport slave.
interface data_bus_arbiter_if;
  logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_mode;
  logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_mode;
  logic        owner;
  logic        bus_r_en, bus_w_en;
  logic [31:0] bus_r_addr, bus_w_addr, bus_w_data, bus_r_data;
  logic [1:0]  bus_r_mode, bus_w_mode, bus_state;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output owner,
    output bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
    output bus_r_mode, bus_w_mode, bus_w_data,
    input  bus_r_data, bus_state
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  owner,
    input  bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
    input  bus_r_mode, bus_w_mode, bus_w_data,
    output bus_r_data, bus_state
  );
endinterface

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-way picker: a lone request wins; a tie goes to master 0
// when fixed is set, otherwise to the master that did not win last time.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed,
  output logic       valid,
  output logic       winner
);

  assign valid = |req;

  // resolve the winner index from the request pattern
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = fixed ? 1'b0 : ~last_grant;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter/sequencer: one transaction at a time,
// registered grant, one-cycle slave strobe, then wait on bus_state for done
// or timeout. Optional grant/timeout statistics when ARB_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate pending requests
// ST_ISSUE | winner latched, gnt visible; strobe registered for next cycle
// ST_WAIT  | strobe visible / waiting on slave done or timeout
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int PRIO_M0 = 0,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  data_bus_arbiter_if.master bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] m0_cnt,
  output logic [15:0] m1_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             txn_m_q, txn_m_d, txn_we_q, txn_we_d;
  logic [31:0]      txn_addr_q, txn_addr_d, txn_wdata_q, txn_wdata_d;
  logic [1:0]       txn_mode_q, txn_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [31:0]      rdata_q [2];
  logic [31:0]      rdata_d [2];
  logic             owner_q, owner_d;
  logic             r_en_q, r_en_d, w_en_q, w_en_d;
  logic [31:0]      r_addr_q, r_addr_d, w_addr_q, w_addr_d, w_data_q, w_data_d;
  logic [1:0]       r_mode_q, r_mode_d, w_mode_q, w_mode_d;
  logic             pick_valid, pick_winner;

  rr_pick2 u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_grant_q),
    .fixed      (PRIO_M0 != 0),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    txn_m_d      = txn_m_q;
    txn_we_d     = txn_we_q;
    txn_addr_d   = txn_addr_q;
    txn_wdata_d  = txn_wdata_q;
    txn_mode_d   = txn_mode_q;
    cnt_d        = cnt_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    owner_d      = owner_q;
    r_en_d       = 1'b0;
    w_en_d       = 1'b0;
    r_addr_d     = '0;
    w_addr_d     = '0;
    w_data_d     = '0;
    r_mode_d     = '0;
    w_mode_d     = '0;
    case (state_q)
      ST_IDLE: begin
        owner_d = 1'b0;
        if (pick_valid) begin
          state_d              = ST_ISSUE;
          last_grant_d         = pick_winner;
          txn_m_d              = pick_winner;
          txn_we_d             = pick_winner ? bus.m1_we    : bus.m0_we;
          txn_addr_d           = pick_winner ? bus.m1_addr  : bus.m0_addr;
          txn_wdata_d          = pick_winner ? bus.m1_wdata : bus.m0_wdata;
          txn_mode_d           = pick_winner ? bus.m1_mode  : bus.m0_mode;
          gnt_d[pick_winner]   = 1'b1;
          owner_d              = pick_winner;
        end
      end
      ST_ISSUE: begin
        if (txn_we_q) begin
          w_en_d   = 1'b1;
          w_addr_d = txn_addr_q;
          w_data_d = txn_wdata_q;
          w_mode_d = txn_mode_q;
        end else begin
          r_en_d   = 1'b1;
          r_addr_d = txn_addr_q;
          r_mode_d = txn_mode_q;
        end
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.bus_state == BS_DONE) begin
          if (!txn_we_q) rdata_d[txn_m_q] = bus.bus_r_data;
          done_d[txn_m_q] = 1'b1;
          owner_d         = 1'b0;
          state_d         = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          if (!txn_we_q) rdata_d[txn_m_q] = '0;
          done_d[txn_m_q] = 1'b1;
          err_d[txn_m_q]  = 1'b1;
          owner_d         = 1'b0;
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 1'b0;
      end
    endcase
  end

  // state register and registered outputs; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      txn_m_q      <= 1'b0;
      txn_we_q     <= 1'b0;
      txn_addr_q   <= '0;
      txn_wdata_q  <= '0;
      txn_mode_q   <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '{default: '0};
      owner_q      <= 1'b0;
      r_en_q       <= 1'b0;
      w_en_q       <= 1'b0;
      r_addr_q     <= '0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      r_mode_q     <= '0;
      w_mode_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      txn_m_q      <= txn_m_d;
      txn_we_q     <= txn_we_d;
      txn_addr_q   <= txn_addr_d;
      txn_wdata_q  <= txn_wdata_d;
      txn_mode_q   <= txn_mode_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      owner_q      <= owner_d;
      r_en_q       <= r_en_d;
      w_en_q       <= w_en_d;
      r_addr_q     <= r_addr_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      r_mode_q     <= r_mode_d;
      w_mode_q     <= w_mode_d;
    end
  end

  assign bus.m0_gnt     = gnt_q[0];
  assign bus.m1_gnt     = gnt_q[1];
  assign bus.m0_done    = done_q[0];
  assign bus.m1_done    = done_q[1];
  assign bus.m0_err     = err_q[0];
  assign bus.m1_err     = err_q[1];
  assign bus.m0_rdata   = rdata_q[0];
  assign bus.m1_rdata   = rdata_q[1];
  assign bus.owner      = owner_q;
  assign bus.bus_r_en   = r_en_q;
  assign bus.bus_w_en   = w_en_q;
  assign bus.bus_r_addr = r_addr_q;
  assign bus.bus_w_addr = w_addr_q;
  assign bus.bus_w_data = w_data_q;
  assign bus.bus_r_mode = r_mode_q;
  assign bus.bus_w_mode = w_mode_q;

`ifdef ARB_STATS_EN
  // saturating per-master grant counters and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_cnt  <= '0;
      m1_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (gnt_d[0] && (m0_cnt != 16'hFFFF)) m0_cnt <= m0_cnt + 16'd1;
      if (gnt_d[1] && (m1_cnt != 16'hFFFF)) m1_cnt <= m1_cnt + 16'd1;
      if ((|err_d) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a round-robin instance (TIMEOUT = 4) checked
// every cycle against a transaction-level model, plus a fixed-priority
// instance whose grant pattern is counted; directed literal expectations.
module tb_data_bus_arbiter;
  import bus_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_arbiter_if ifc ();
  data_bus_arbiter_if ifx ();

`ifdef ARB_STATS_EN
  logic [15:0] c0_cnt, c1_cnt, ce_cnt, x0_cnt, x1_cnt, xe_cnt;
`endif

  data_bus_arbiter #(.PRIO_M0(0), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
`ifdef ARB_STATS_EN
    , .m0_cnt(c0_cnt), .m1_cnt(c1_cnt), .err_cnt(ce_cnt)
`endif
  );

  data_bus_arbiter #(.PRIO_M0(1), .TIMEOUT(TMO), .CNT_W(8)) dut_fx (
    .clk(clk), .rst(rst), .bus(ifx)
`ifdef ARB_STATS_EN
    , .m0_cnt(x0_cnt), .m1_cnt(x1_cnt), .err_cnt(xe_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // mage counts cycles since the grant became visible: 0 = grant cycle,
  // 1 = strobe cycle, 1..TMO = cycles spent waiting for the slave.
  bit          mb = 0, mw = 0, mwe = 0, mlast = 1, mdv = 0, mdw = 0, mde = 0, mwin;
  logic [31:0] maddr = 0, mwdata = 0;
  logic [1:0]  mmode = 0;
  int          mage = 0;
  logic [31:0] mrd [2] = '{0, 0};
  int          mg [2] = '{0, 0};
  int          me = 0;

  function automatic bit pick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  always_comb mwin = pick(ifc.m0_req, ifc.m1_req, mlast);

  always @(posedge clk) begin
    if (rst) begin
      mb <= 0; mlast <= 1; mdv <= 0; mage <= 0; me <= 0;
      mrd[0] <= 0; mrd[1] <= 0; mg[0] <= 0; mg[1] <= 0;
    end else begin
      mdv <= 0;
      if (!mb) begin
        if (ifc.m0_req || ifc.m1_req) begin
          mb     <= 1;
          mage   <= 0;
          mw     <= mwin;
          mlast  <= mwin;
          mwe    <= mwin ? ifc.m1_we    : ifc.m0_we;
          maddr  <= mwin ? ifc.m1_addr  : ifc.m0_addr;
          mwdata <= mwin ? ifc.m1_wdata : ifc.m0_wdata;
          mmode  <= mwin ? ifc.m1_mode  : ifc.m0_mode;
          mg[mwin] <= mg[mwin] + 1;
        end
      end else if (mage == 0) begin
        mage <= 1;
      end else if (ifc.bus_state == BS_DONE || mage == TMO) begin
        mb  <= 0;
        mdv <= 1;
        mdw <= mw;
        mde <= (ifc.bus_state != BS_DONE);
        if (!mwe) mrd[mw] <= (ifc.bus_state == BS_DONE) ? ifc.bus_r_data : 32'd0;
        if (ifc.bus_state != BS_DONE) me <= me + 1;
      end else begin
        mage <= mage + 1;
      end
    end
  end

  wire m_st = mb && (mage == 1);
  wire m_rd = m_st && !mwe;
  wire m_wr = m_st && mwe;

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m0_gnt",  32'(ifc.m0_gnt),  32'(mb && mage == 0 && !mw));
      chk("m1_gnt",  32'(ifc.m1_gnt),  32'(mb && mage == 0 && mw));
      chk("m0_done", 32'(ifc.m0_done), 32'(mdv && !mdw));
      chk("m1_done", 32'(ifc.m1_done), 32'(mdv && mdw));
      chk("m0_err",  32'(ifc.m0_err),  32'(mdv && !mdw && mde));
      chk("m1_err",  32'(ifc.m1_err),  32'(mdv && mdw && mde));
      chk("m0_rdata", ifc.m0_rdata, mrd[0]);
      chk("m1_rdata", ifc.m1_rdata, mrd[1]);
      chk("owner",    32'(ifc.owner), 32'(mb && mw));
      chk("bus_r_en", 32'(ifc.bus_r_en), 32'(m_rd));
      chk("bus_w_en", 32'(ifc.bus_w_en), 32'(m_wr));
      chk("bus_r_addr", ifc.bus_r_addr, m_rd ? maddr : 32'd0);
      chk("bus_w_addr", ifc.bus_w_addr, m_wr ? maddr : 32'd0);
      chk("bus_w_data", ifc.bus_w_data, m_wr ? mwdata : 32'd0);
      chk("bus_r_mode", 32'(ifc.bus_r_mode), 32'(m_rd ? mmode : 2'b00));
      chk("bus_w_mode", 32'(ifc.bus_w_mode), 32'(m_wr ? mmode : 2'b00));
`ifdef ARB_STATS_EN
      chk("m0_cnt",  32'(c0_cnt), 32'(mg[0]));
      chk("m1_cnt",  32'(c1_cnt), 32'(mg[1]));
      chk("err_cnt", 32'(ce_cnt), 32'(me));
`endif
    end
  end

  int gq[$];
  always @(negedge clk) begin
    if (cmp_on) begin
      if (ifc.m0_gnt) gq.push_back(0);
      if (ifc.m1_gnt) gq.push_back(1);
    end
  end

  // ---------------- slave responder ----------------
  // slave_lat = cycles after the strobe cycle until DONE; 0 = never answers
  int          slave_lat = 1;
  logic [31:0] slave_rdata = 0;
  logic [1:0]  busy_code = BS_BUSY;
  initial begin
    int rem;
    rem = -2;
    ifc.bus_state  = BS_IDLE;
    ifc.bus_r_data = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (ifc.bus_r_en || ifc.bus_w_en) begin
        rem = (slave_lat == 0) ? -1 : slave_lat;
        ifc.bus_state = busy_code;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          ifc.bus_state  = BS_DONE;
          ifc.bus_r_data = slave_rdata;
        end else begin
          ifc.bus_state = busy_code;
        end
      end else if (rem == 0) begin
        rem = -2;
        ifc.bus_state  = BS_IDLE;
        ifc.bus_r_data = 32'h0BAD_0BAD;
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic drive(input int m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] md);
    if (m == 0) begin
      ifc.m0_req = req; ifc.m0_we = we; ifc.m0_addr = a; ifc.m0_wdata = d; ifc.m0_mode = md;
    end else begin
      ifc.m1_req = req; ifc.m1_we = we; ifc.m1_addr = a; ifc.m1_wdata = d; ifc.m1_mode = md;
    end
  endtask

  function automatic logic done_of(input int m);
    return (m == 0) ? ifc.m0_done : ifc.m1_done;
  endfunction

  // n back-to-back transactions with req held high between them
  task automatic master_seq(input int m, input int n, input logic we, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int k;
      drive(m, 1'b1, we, base + 32'(i * 4), base ^ 32'(i + 1), MODE_WORD);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done_of(m) && k < 60);
      chk($sformatf("m%0d_done_seen", m), 32'(done_of(m)), 32'd1);
    end
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, k;
    int exp_rr [4];
    exp_rr = '{0, 1, 0, 1};
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    ifx.m0_req = 1; ifx.m0_we = 0; ifx.m0_addr = 32'h40; ifx.m0_wdata = 0; ifx.m0_mode = 2'b10;
    ifx.m1_req = 1; ifx.m1_we = 0; ifx.m1_addr = 32'h80; ifx.m1_wdata = 0; ifx.m1_mode = 2'b10;
    ifx.bus_state = BS_DONE; ifx.bus_r_data = 32'h7777_7777;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_owner", 32'(ifc.owner), 32'd0);
    chk("rst_m0_rdata", ifc.m0_rdata, 32'd0);
    chk("rst_bus_r_addr", ifc.bus_r_addr, 32'd0);
    rst = 1'b0;

    // fixed priority, both masters always requesting, slave always done
    n0 = 0; n1 = 0;
    repeat (30) begin
      @(negedge clk);
      n0 += int'(ifx.m0_gnt);
      n1 += int'(ifx.m1_gnt);
    end
    chk("fx_m0_grants", 32'(n0), 32'd10);
    chk("fx_m1_grants", 32'(n1), 32'd0);

    // M0 word read, slave done 3 cycles after the strobe
    slave_lat = 3; slave_rdata = 32'hDEAD_BEEF;
    drive(0, 1'b1, 1'b0, 32'h1004, 32'd0, 2'b10);
    @(negedge clk); chk("t1_gnt_n1", 32'(ifc.m0_gnt), 32'd1);
    @(negedge clk); chk("t1_r_en_n2", 32'(ifc.bus_r_en), 32'd1);
    chk("t1_r_addr", ifc.bus_r_addr, 32'h1004);
    chk("t1_r_mode", 32'(ifc.bus_r_mode), 32'd2);
    @(negedge clk); chk("t1_r_en_n3", 32'(ifc.bus_r_en), 32'd0);
    @(negedge clk);
    @(negedge clk); chk("t1_done_n5", 32'(ifc.m0_done), 32'd0);
    @(negedge clk); chk("t1_done_n6", 32'(ifc.m0_done), 32'd1);
    chk("t1_rdata", ifc.m0_rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(ifc.m0_err), 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    repeat (2) @(negedge clk);

    // round-robin alternation from reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    gq.delete();
    slave_lat = 1; slave_rdata = 32'h5555_0000;
    fork
      master_seq(0, 2, 1'b0, 32'h100);
      master_seq(1, 2, 1'b0, 32'h200);
    join
    chk("rr_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk($sformatf("rr_order_%0d", i), 32'(gq[i]), 32'(exp_rr[i]));
    @(negedge clk);

    // M1 byte write, slave busy with the reserved code before done
    busy_code = 2'b11; slave_lat = 2;
    drive(1, 1'b1, 1'b1, 32'h10, 32'hA5, 2'b00);
    @(negedge clk); chk("t3_gnt", 32'(ifc.m1_gnt), 32'd1);
    chk("t3_owner", 32'(ifc.owner), 32'd1);
    @(negedge clk); chk("t3_w_en", 32'(ifc.bus_w_en), 32'd1);
    chk("t3_w_addr", ifc.bus_w_addr, 32'h10);
    chk("t3_w_data", ifc.bus_w_data, 32'hA5);
    chk("t3_w_mode", 32'(ifc.bus_w_mode), 32'd0);
    chk("t3_r_en", 32'(ifc.bus_r_en), 32'd0);
    k = 0;
    while (!ifc.m1_done && k < 20) begin @(negedge clk); k++; end
    chk("t3_done_lat", 32'(k), 32'd3);
    chk("t3_err", 32'(ifc.m1_err), 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    busy_code = BS_BUSY;
    @(negedge clk);

    // timeout with the slave stuck busy, then a normal request
    slave_lat = 0; slave_rdata = 32'hFFFF_FFFF;
    drive(0, 1'b1, 1'b0, 32'h2000, 32'd0, 2'b01);
    k = 0;
    do begin @(negedge clk); k++; end while (!ifc.m0_done && k < 20);
    chk("t4_tmo_lat", 32'(k), 32'd6);
    chk("t4_err", 32'(ifc.m0_err), 32'd1);
    chk("t4_rdata", ifc.m0_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    slave_lat = 1; slave_rdata = 32'h1234_5678;
    master_seq(0, 1, 1'b0, 32'h2004);
    chk("t4_next_rdata", ifc.m0_rdata, 32'h1234_5678);
    chk("t4_next_err", 32'(ifc.m0_err), 32'd0);
    @(negedge clk);

    // reset during WAIT abandons the transaction
    slave_lat = 0;
    drive(0, 1'b1, 1'b0, 32'h3000, 32'd0, 2'b10);
    k = 0;
    do begin @(negedge clk); k++; end while (!ifc.bus_r_en && k < 10);
    chk("t5_strobe_seen", 32'(ifc.bus_r_en), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_owner", 32'(ifc.owner), 32'd0);
    chk("t5_done", 32'(ifc.m0_done), 32'd0);
    chk("t5_rdata", ifc.m0_rdata, 32'd0);
    chk("t5_r_en", 32'(ifc.bus_r_en), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("t5_no_done", 32'(ifc.m0_done), 32'd0);
    end
    gq.delete();
    slave_lat = 1; slave_rdata = 32'h0000_00C3;
    fork
      master_seq(0, 1, 1'b0, 32'h400);
      master_seq(1, 1, 1'b0, 32'h500);
    join
    chk("t5_tie_count", 32'(gq.size()), 32'd2);
    if (gq.size() >= 2) begin
      chk("t5_tie_first", 32'(gq[0]), 32'd0);
      chk("t5_tie_second", 32'(gq[1]), 32'd1);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Two-master arbiter and sequencer for the shared data bus that feeds data memory, GPIO and terminal through their busdev decoders.
- Master 0 is the CPU core data port; master 1 is a debug/DMA master (memory peek/poke from dbgtoplevel).
- Serialises one transaction at a time with round-robin or fixed priority.
- Waits on the slave bus_state handshake and returns read data, completion and timeout error to the winning master.

Parameters:
PRIO_M0, 0, 1 = fixed priority to master 0; 0 = round-robin
TIMEOUT, 255, WAIT-state cycles before abort with error; 0 disables timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  system clock (cpuclk domain)
rst  in  1  synchronous reset, active-high
mX_req  in  1  request (X = 0, 1); held high until mX_done
mX_we  in  1  1 = write, 0 = read
mX_addr  in  32  byte address
mX_wdata  in  32  write data
mX_mode  in  2  size: 00 byte, 01 half, 10 word
mX_gnt  out  1  one-cycle pulse when master X wins arbitration
mX_done  out  1  one-cycle completion pulse
mX_err  out  1  valid with mX_done; 1 = timeout
mX_rdata  out  32  read data; valid with mX_done, held until next done to X
owner  out  1  master of the current transaction; 0 when idle
bus_r_en, bus_w_en  out  1  slave strobes
bus_r_addr, bus_w_addr  out  32  slave addresses
bus_r_mode, bus_w_mode  out  2  slave sizes
bus_w_data  out  32  slave write data
bus_r_data  in  32  muxed slave read data
bus_state  in  2  00 idle, 01 busy, 10 done, 11 reserved (treated as busy)

Behaviour:
- Reset: FSM = IDLE. All outputs 0: gnt, done, err, rdata, bus strobes, addr, data, mode, owner. last_grant = 1, so master 0 wins the first tie.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, no request: stay.
- IDLE, any request: pick winner.
  - Single request wins.
  - Tie with PRIO_M0 = 0: the master not equal to last_grant wins.
  - Tie with PRIO_M0 = 1: master 0 wins.
  - Latch we/addr/wdata/mode of the winner; pulse mX_gnt; set owner and last_grant; go ISSUE.
- ISSUE: exactly one cycle.
  - Assert bus_r_en (read) or bus_w_en (write) with latched addr/mode/data.
  - The other strobe stays 0; addr/mode/data are driven on the matching bus only, with the other bus at 0.
  - Clear timeout counter; go WAIT.
- WAIT, bus_state == 10:
  - Read: capture bus_r_data into mX_rdata. Write: mX_rdata unchanged.
  - Pulse mX_done with err = 0; go IDLE.
- WAIT, timeout: counter increments each cycle; when it reaches TIMEOUT (TIMEOUT != 0), pulse mX_done with err = 1. On a read, mX_rdata = 0. Go IDLE.
- WAIT, bus_state 00/01/11: keep waiting.
- Latency: req in cycle N -> gnt in N+1 (registered) -> bus strobe in N+2. If the slave reports done in N+3, mX_done is in N+4.
- Back-to-back: the cycle after done returns to IDLE and re-arbitrates. A master may keep req high for a new transaction, but its fields are sampled only in IDLE.
- req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- Misaligned address versus mode: passed through unchanged; alignment is slave responsibility.
- rst asserted in any state: immediate return to IDLE. No done pulse; an in-flight transaction is abandoned.
- Non-owner outputs gnt, done and err are always 0.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs m0_cnt[15:0], m1_cnt[15:0] (grants per master) and err_cnt[15:0] (timeouts).
  - All saturating at 16'hFFFF; cleared by rst.
  - Readable by the debug interface.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package bus_pkg holds:
  - bus_state encodings (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10);
  - mode encodings (BYTE, HALF, WORD);
  - arbiter FSM state enum.
- Sub-module rr_pick2: combinational 2-way picker.
  - Inputs: req[1:0], last_grant, fixed.
  - Outputs: valid, winner.

Test Plan:
- M0 read, addr 0x1004, mode 10; slave done 3 cycles after bus_r_en with bus_r_data 0xDEADBEEF -> m0_gnt at N+1, bus_r_en one cycle at N+2, m0_done at N+6 with m0_rdata 0xDEADBEEF and err = 0.
- Both masters request continuously, PRIO_M0 = 0 -> grants alternate M0, M1, M0, M1; with PRIO_M0 = 1, M0 is granted on every arbitration.
- M1 write, addr 0x10, wdata 0xA5, mode 00 -> bus_w_en one cycle with bus_w_addr 0x10, bus_w_data 0xA5, bus_w_mode 00; bus_r_en stays 0.
- TIMEOUT = 4, slave stuck at 01 -> m0_done with m0_err = 1 four cycles after WAIT entry, rdata 0; next request is served.
- rst pulsed during WAIT -> no done pulse, all outputs 0, and the next tie goes to M0.
- ARB_STATS_EN defined: 3 M0 grants, 2 M1 grants, 1 timeout -> m0_cnt = 3, m1_cnt = 2, err_cnt = 1.
